fetch_arb: RTL and testbench

- Owns the single shared instruction/data memory port and sequences instruction fetch for the IF stage.
- Arbitrates each cycle between the fetch stream and the memory-access stage's data requests, and maintains the fetch PC, including branch redirects.
- Produces the pc/instr/ia_valid triple consumed by the IF stage.
- Holds one fetched word in a skid buffer when the pipeline stalls, so no fetch is lost.

---
 rtl/fetch_arb.sv | 198 +++++++++++++++++++
 tb/tb_fetch_arb.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_arb.sv
`default_nettype none
// ============================================================================
// Module   : fetch_arb
// Purpose  : Shared memory-port arbiter and IF fetch sequencer with skid buffer.
//            Optional perf counters are enabled by defining FETCH_ARB_PERF_EN.
// Revision : 1.0
// ============================================================================
module fetch_arb #(
    parameter int                ADDR_W         = 24,
    parameter int                DATA_W         = 24,
    parameter logic [ADDR_W-1:0] RESET_PC       = '0,
    parameter int                MAX_DATA_BURST = 4
) (
    input  logic              iw_clk,
    input  logic              iw_rst_n,
    input  logic              iw_stall,
    input  logic              iw_redirect,
    input  logic [ADDR_W-1:0] iw_redirect_pc,
    input  logic              iw_d_req,
    input  logic              iw_d_we,
    input  logic [ADDR_W-1:0] iw_d_addr,
    input  logic [DATA_W-1:0] iw_d_wdata,
    output logic              ow_d_ack,
    output logic [DATA_W-1:0] ow_d_rdata,
    output logic              ow_mem_en,
    output logic              ow_mem_we,
    output logic [ADDR_W-1:0] ow_mem_addr,
    output logic [DATA_W-1:0] ow_mem_wdata,
    input  logic [DATA_W-1:0] iw_mem_rdata,
    output logic              ow_ia_valid,
    output logic [ADDR_W-1:0] ow_pc,
    output logic [DATA_W-1:0] ow_instr
`ifdef FETCH_ARB_PERF_EN
    ,
    output logic [15:0]       ow_starve_cnt,
    output logic [15:0]       ow_dgrant_cnt
`endif
);

    localparam logic [3:0] MAX_BURST = 4'(MAX_DATA_BURST);

    typedef enum logic [0:0] {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [ADDR_W-1:0] fetch_pc;
    logic [3:0]        burst_cnt;
    logic              skid_valid;
    logic [ADDR_W-1:0] skid_pc;
    logic [DATA_W-1:0] skid_instr;
    logic              d_tag;
    logic              d_tag_we;
    logic              f_tag;
    logic [ADDR_W-1:0] f_tag_pc;

    logic              run;
    logic              skid_drain;
    logic              fetch_eligible;
    logic              grant_data;
    logic              grant_fetch;
    logic              fetch_live;
    logic              skid_capture;
    logic [3:0]        burst_nxt;

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            state <= S_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_BOOT:  state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_BOOT;
        endcase
    end

    // A full skid buffer that drains this cycle frees the slot for a new fetch.
    always_comb begin
        run            = (state == S_RUN);
        skid_drain     = skid_valid && !iw_stall && !iw_redirect;
        fetch_eligible = run && !iw_stall && !iw_redirect && (!skid_valid || skid_drain);
        grant_data     = run && iw_d_req && ((burst_cnt < MAX_BURST) || !fetch_eligible);
        grant_fetch    = fetch_eligible && !grant_data;
        fetch_live     = f_tag && !iw_redirect;
        skid_capture   = fetch_live && iw_stall;
    end

    always_comb begin
        burst_nxt = burst_cnt;
        if (grant_data) begin
            if (!fetch_eligible) begin
                burst_nxt = 4'd0;
            end else if (burst_cnt != 4'hF) begin
                burst_nxt = burst_cnt + 4'd1;
            end
        end else if (grant_fetch) begin
            burst_nxt = 4'd0;
        end
    end

    always_comb begin
        ow_mem_en    = grant_data || grant_fetch;
        ow_mem_we    = grant_data && iw_d_we;
        ow_mem_addr  = '0;
        ow_mem_wdata = '0;
        if (grant_data) begin
            ow_mem_addr = iw_d_addr;
            if (iw_d_we) begin
                ow_mem_wdata = iw_d_wdata;
            end
        end else if (grant_fetch) begin
            ow_mem_addr = fetch_pc;
        end
    end

    always_comb begin
        ow_d_ack    = d_tag;
        ow_d_rdata  = (d_tag && !d_tag_we) ? iw_mem_rdata : '0;
        ow_ia_valid = 1'b0;
        ow_pc       = '0;
        ow_instr    = '0;
        if (fetch_live && !iw_stall) begin
            ow_ia_valid = 1'b1;
            ow_pc       = f_tag_pc;
            ow_instr    = iw_mem_rdata;
        end else if (skid_drain) begin
            ow_ia_valid = 1'b1;
            ow_pc       = skid_pc;
            ow_instr    = skid_instr;
        end
    end

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            fetch_pc   <= RESET_PC;
            burst_cnt  <= 4'd0;
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= '0;
            d_tag      <= 1'b0;
            d_tag_we   <= 1'b0;
            f_tag      <= 1'b0;
            f_tag_pc   <= '0;
        end else begin
            burst_cnt <= burst_nxt;
            d_tag     <= grant_data;
            d_tag_we  <= grant_data && iw_d_we;
            f_tag     <= grant_fetch;

            if (grant_fetch) begin
                f_tag_pc <= fetch_pc;
            end

            if (iw_redirect) begin
                fetch_pc <= iw_redirect_pc;
            end else if (grant_fetch) begin
                fetch_pc <= fetch_pc + ADDR_W'(1);
            end

            if (iw_redirect) begin
                skid_valid <= 1'b0;
            end else if (skid_capture) begin
                skid_valid <= 1'b1;
                skid_pc    <= f_tag_pc;
                skid_instr <= iw_mem_rdata;
            end else if (skid_drain) begin
                skid_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_ARB_PERF_EN
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            ow_starve_cnt <= 16'd0;
            ow_dgrant_cnt <= 16'd0;
        end else begin
            if (grant_data && fetch_eligible && (ow_starve_cnt != 16'hFFFF)) begin
                ow_starve_cnt <= ow_starve_cnt + 16'd1;
            end
            if (grant_data && (ow_dgrant_cnt != 16'hFFFF)) begin
                ow_dgrant_cnt <= ow_dgrant_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_arb.sv
`default_nettype none
// Bench for fetch_arb: directed vector table, reset-in-flight sequence and a
// randomized run checked against a queue-based reference model.
module tb_fetch_arb;

    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, redirect, d_req, d_we;
    logic [23:0] redirect_pc, d_addr, d_wdata, mem_rdata;
    logic        d_ack, mem_en, mem_we, ia_valid;
    logic [23:0] d_rdata, mem_addr, mem_wdata, pc, instr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_arb #(
        .ADDR_W(24), .DATA_W(24), .RESET_PC(24'h0), .MAX_DATA_BURST(MAXB)
    ) dut (
        .iw_clk(clk), .iw_rst_n(rst_n), .iw_stall(stall), .iw_redirect(redirect),
        .iw_redirect_pc(redirect_pc), .iw_d_req(d_req), .iw_d_we(d_we),
        .iw_d_addr(d_addr), .iw_d_wdata(d_wdata), .ow_d_ack(d_ack),
        .ow_d_rdata(d_rdata), .ow_mem_en(mem_en), .ow_mem_we(mem_we),
        .ow_mem_addr(mem_addr), .ow_mem_wdata(mem_wdata), .iw_mem_rdata(mem_rdata),
        .ow_ia_valid(ia_valid), .ow_pc(pc), .ow_instr(instr)
    );

    function automatic logic [23:0] hash(input logic [23:0] a);
        return {a[11:0], a[23:12]} ^ 24'h5A3C96 ^ (a << 3);
    endfunction

    // Synchronous memory: contents are a fixed function of the address.
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= hash(mem_addr);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic rd, input logic [23:0] rpc,
                         input logic dq, input logic dw, input logic [23:0] da,
                         input logic [23:0] dd);
        stall = st; redirect = rd; redirect_pc = rpc;
        d_req = dq; d_we = dw; d_addr = da; d_wdata = dd;
    endtask

    task automatic check_outputs(input string tag, input logic e_en, input logic e_we,
                                 input logic [23:0] e_ad, input logic [23:0] e_dd,
                                 input logic e_ak, input logic [23:0] e_rd,
                                 input logic e_ia, input logic [23:0] e_pc,
                                 input logic [23:0] e_in);
        chk({tag, " mem_en"}, 32'(mem_en), 32'(e_en));
        if (e_en) begin
            chk({tag, " mem_we"}, 32'(mem_we), 32'(e_we));
            chk({tag, " mem_addr"}, 32'(mem_addr), 32'(e_ad));
            if (e_we) chk({tag, " mem_wdata"}, 32'(mem_wdata), 32'(e_dd));
        end
        chk({tag, " d_ack"}, 32'(d_ack), 32'(e_ak));
        if (e_ak) chk({tag, " d_rdata"}, 32'(d_rdata), 32'(e_rd));
        chk({tag, " ia_valid"}, 32'(ia_valid), 32'(e_ia));
        chk({tag, " pc"}, 32'(pc), 32'(e_pc));
        chk({tag, " instr"}, 32'(instr), 32'(e_in));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " mem_en"}, 32'(mem_en), 0);
        chk({tag, " mem_we"}, 32'(mem_we), 0);
        chk({tag, " mem_addr"}, 32'(mem_addr), 0);
        chk({tag, " mem_wdata"}, 32'(mem_wdata), 0);
        chk({tag, " d_ack"}, 32'(d_ack), 0);
        chk({tag, " d_rdata"}, 32'(d_rdata), 0);
        chk({tag, " ia_valid"}, 32'(ia_valid), 0);
        chk({tag, " pc"}, 32'(pc), 0);
        chk({tag, " instr"}, 32'(instr), 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic st, rd; logic [23:0] rpc;
        logic dq, dw; logic [23:0] da, dd;
        logic en, we; logic [23:0] ad;
        logic ak; logic [23:0] rdv;
        logic ia; logic [23:0] pc, ins;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic rd, input logic [23:0] rpc,
                                input logic dq, input logic dw, input logic [23:0] da,
                                input logic [23:0] dd, input logic en, input logic we,
                                input logic [23:0] ad, input logic ak, input logic [23:0] rdv,
                                input logic ia, input logic [23:0] p);
        vec_t v;
        v.st = st; v.rd = rd; v.rpc = rpc; v.dq = dq; v.dw = dw; v.da = da; v.dd = dd;
        v.en = en; v.we = we; v.ad = ad; v.ak = ak; v.rdv = rdv; v.ia = ia; v.pc = p;
        v.ins = ia ? hash(p) : 24'h0;
        return v;
    endfunction

    vec_t tv[35];

    // ---------------- reference model ----------------
    typedef struct { logic is_data; logic we; logic [23:0] addr; } flight_t;
    typedef struct { logic [23:0] pc; logic [23:0] instr; } word_t;

    flight_t     fq[$];
    word_t       sq[$];
    bit          m_boot;
    int unsigned m_pc;
    int          m_bcnt;

    task automatic model_reset();
        fq.delete(); sq.delete();
        m_boot = 1'b1; m_pc = 0; m_bcnt = 0;
    endtask

    task automatic model_cycle(input logic st, input logic rd, input logic [23:0] rpc,
                               input logic dq, input logic dw, input logic [23:0] da,
                               input logic [23:0] dd, input string tag);
        flight_t f, g;
        word_t   w;
        bit      elig, drain, have_g;
        logic    e_en, e_we, e_ak, e_ia;
        logic [23:0] e_ad, e_dd, e_rd, e_pc, e_in;
        drive(st, rd, rpc, dq, dw, da, dd);
        #1;
        e_en = 0; e_we = 0; e_ak = 0; e_ia = 0;
        e_ad = 0; e_dd = 0; e_rd = 0; e_pc = 0; e_in = 0;
        have_g = 0;
        g = '{1'b0, 1'b0, 24'h0};
        drain = (sq.size() != 0) && !st && !rd;
        elig  = !m_boot && !st && !rd && (sq.size() == 0 || drain);
        if (!m_boot && dq && (m_bcnt < MAXB || !elig)) begin
            have_g = 1; g = '{1'b1, dw, da};
            e_en = 1; e_we = dw; e_ad = da; e_dd = dd;
            m_bcnt = elig ? ((m_bcnt < 15) ? m_bcnt + 1 : 15) : 0;
        end else if (elig) begin
            have_g = 1; g = '{1'b0, 1'b0, 24'(m_pc)};
            e_en = 1; e_ad = 24'(m_pc);
            m_pc = (m_pc + 1) % 32'h0100_0000;
            m_bcnt = 0;
        end
        if (fq.size() != 0) begin
            f = fq.pop_front();
            if (f.is_data) begin
                e_ak = 1; e_rd = f.we ? 24'h0 : hash(f.addr);
            end else if (!rd) begin
                if (!st) begin
                    e_ia = 1; e_pc = f.addr; e_in = hash(f.addr);
                end else begin
                    sq.push_back('{f.addr, hash(f.addr)});
                end
            end
        end
        if (drain) begin
            w = sq.pop_front();
            e_ia = 1; e_pc = w.pc; e_in = w.instr;
        end
        if (rd) begin
            m_pc = {8'h0, rpc};
            sq.delete();
        end
        if (have_g) fq.push_back(g);
        m_boot = 0;
        check_outputs(tag, e_en, e_we, e_ad, e_dd, e_ak, e_rd, e_ia, e_pc, e_in);
        @(negedge clk);
    endtask

    initial begin
        // stall rd rpc | dq dw da dd | en we ad | ak rdata | ia pc
        tv[0]  = mk(0,0,0,        0,0,0,0,             0,0,0,         0,0,          0,0);
        tv[1]  = mk(0,0,0,        0,0,0,0,             1,0,24'h0,     0,0,          0,0);
        tv[2]  = mk(0,0,0,        0,0,0,0,             1,0,24'h1,     0,0,          1,24'h0);
        tv[3]  = mk(0,0,0,        1,0,24'h200,0,       1,0,24'h200,   0,0,          1,24'h1);
        tv[4]  = mk(0,0,0,        1,0,24'h201,0,       1,0,24'h201,   1,hash(24'h200),0,0);
        tv[5]  = mk(0,0,0,        1,0,24'h202,0,       1,0,24'h202,   1,hash(24'h201),0,0);
        tv[6]  = mk(0,0,0,        1,0,24'h203,0,       1,0,24'h203,   1,hash(24'h202),0,0);
        tv[7]  = mk(0,0,0,        1,0,24'h204,0,       1,0,24'h2,     1,hash(24'h203),0,0);
        tv[8]  = mk(0,0,0,        1,0,24'h204,0,       1,0,24'h204,   0,0,          1,24'h2);
        tv[9]  = mk(0,0,0,        1,0,24'h205,0,       1,0,24'h205,   1,hash(24'h204),0,0);
        tv[10] = mk(0,0,0,        1,0,24'h206,0,       1,0,24'h206,   1,hash(24'h205),0,0);
        tv[11] = mk(0,0,0,        1,0,24'h207,0,       1,0,24'h207,   1,hash(24'h206),0,0);
        tv[12] = mk(0,0,0,        1,0,24'h208,0,       1,0,24'h3,     1,hash(24'h207),0,0);
        tv[13] = mk(0,0,0,        1,0,24'h208,0,       1,0,24'h208,   0,0,          1,24'h3);
        tv[14] = mk(0,0,0,        1,0,24'h209,0,       1,0,24'h209,   1,hash(24'h208),0,0);
        tv[15] = mk(0,0,0,        0,0,0,0,             1,0,24'h4,     1,hash(24'h209),0,0);
        tv[16] = mk(0,0,0,        0,0,0,0,             1,0,24'h5,     0,0,          1,24'h4);
        tv[17] = mk(0,1,24'h100,  0,0,0,0,             0,0,0,         0,0,          0,0);
        tv[18] = mk(0,0,0,        0,0,0,0,             1,0,24'h100,   0,0,          0,0);
        tv[19] = mk(0,0,0,        0,0,0,0,             1,0,24'h101,   0,0,          1,24'h100);
        tv[20] = mk(0,1,24'h010,  0,0,0,0,             0,0,0,         0,0,          0,0);
        tv[21] = mk(0,0,0,        0,0,0,0,             1,0,24'h010,   0,0,          0,0);
        tv[22] = mk(1,0,0,        0,0,0,0,             0,0,0,         0,0,          0,0);
        tv[23] = mk(1,0,0,        0,0,0,0,             0,0,0,         0,0,          0,0);
        tv[24] = mk(1,0,0,        0,0,0,0,             0,0,0,         0,0,          0,0);
        tv[25] = mk(0,0,0,        0,0,0,0,             1,0,24'h011,   0,0,          1,24'h010);
        tv[26] = mk(0,0,0,        0,0,0,0,             1,0,24'h012,   0,0,          1,24'h011);
        tv[27] = mk(0,0,0,        0,0,0,0,             1,0,24'h013,   0,0,          1,24'h012);
        tv[28] = mk(0,1,24'hFFFFFF,0,0,0,0,            0,0,0,         0,0,          0,0);
        tv[29] = mk(0,0,0,        0,0,0,0,             1,0,24'hFFFFFF,0,0,          0,0);
        tv[30] = mk(0,0,0,        0,0,0,0,             1,0,24'h000000,0,0,          1,24'hFFFFFF);
        tv[31] = mk(0,0,0,        0,0,0,0,             1,0,24'h000001,0,0,          1,24'h0);
        tv[32] = mk(0,0,0,        1,1,24'h300,24'hABCDEF,1,1,24'h300, 0,0,          1,24'h1);
        tv[33] = mk(0,0,0,        0,0,0,0,             1,0,24'h2,     1,24'h0,      0,0);
        tv[34] = mk(0,0,0,        0,0,0,0,             1,0,24'h3,     0,0,          1,24'h2);

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 35; i++) begin
            drive(tv[i].st, tv[i].rd, tv[i].rpc, tv[i].dq, tv[i].dw, tv[i].da, tv[i].dd);
            #1;
            check_outputs($sformatf("row%0d", i), tv[i].en, tv[i].we, tv[i].ad, tv[i].dd,
                          tv[i].ak, tv[i].rdv, tv[i].ia, tv[i].pc, tv[i].ins);
            @(negedge clk);
        end

        // Reset in the middle of a data read: the pending ack must vanish at once.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        model_cycle(0, 0, 0, 0, 0, 0, 0, "pre boot");
        model_cycle(0, 0, 0, 0, 0, 0, 0, "pre f0");
        model_cycle(0, 0, 0, 0, 0, 0, 0, "pre f1");
        model_cycle(0, 0, 0, 1, 0, 24'h400, 0, "pre read");
        #2 rst_n = 1'b0;
        #1 chk_all_zero("mid-read reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            model_cycle(0, 0, 0, (i < 2) ? 1'b1 : 1'b0, 0, 24'h400, 0, $sformatf("post%0d", i));
        end

        // Randomized run against the model.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            logic st, rd, dq, dw;
            logic [23:0] rpc, da, dd;
            st  = ($urandom_range(0, 4) == 0);
            rd  = ($urandom_range(0, 19) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? 24'hFFFFFE : 24'($urandom);
            dq  = ($urandom_range(0, 2) == 0);
            dw  = $urandom_range(0, 1) == 1;
            da  = 24'($urandom);
            dd  = 24'($urandom);
            model_cycle(st, rd, rpc, dq, dw, da, dd, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
